// File: rtl/lighthouse_emitter_pkg.sv
// Shared constants and state type for the lighthouse sensor emulator.
// Sync pulse lengths are built from a base plus weighted flag steps.
package lighthouse_emitter_pkg;

    localparam int CNT_W          = 24;
    localparam int SYNC_BASE      = 3072;
    localparam int SYNC_AXIS_STEP = 512;
    localparam int SYNC_DATA_STEP = 1024;
    localparam int SYNC_SKIP_STEP = 2048;
    localparam int SWEEP_MAX_US   = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC0,
        ST_GAP0,
        ST_SYNC1,
        ST_WAIT_SWEEP,
        ST_SWEEP,
        ST_TAIL
    } state_t;

endpackage

// File: rtl/lighthouse_emitter_sync_encode.sv
// Combinational sync-length encoder: maps the (skip, data, axis) flags
// of one sync pulse to its low time in clocks.
module lighthouse_sync_encode
    import lighthouse_emitter_pkg::*;
(
    input  logic             skip_i,
    input  logic             data_i,
    input  logic             axis_i,
    output logic [CNT_W-1:0] len_o
);

    assign len_o = CNT_W'(SYNC_BASE)
                 + (axis_i ? CNT_W'(SYNC_AXIS_STEP) : '0)
                 + (data_i ? CNT_W'(SYNC_DATA_STEP) : '0)
                 + (skip_i ? CNT_W'(SYNC_SKIP_STEP) : '0);

endmodule

// File: rtl/lighthouse_emitter.sv
// Lighthouse base-station emulator: drives a sensor-style pin with two sync
// pulses and one sweep pulse per frame, cycling through four frames.
// Optional OOTX data bits are enabled by defining LIGHTHOUSE_EMITTER_OOTX_EN.
module lighthouse_emitter
    import lighthouse_emitter_pkg::*;
#(
    parameter int CLOCKS_PER_MICROSECOND = 48,
    parameter int FRAME_CLOCKS           = 400000,
    parameter int SYNC_GAP               = 19200,
    parameter int SWEEP_LEN              = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [23:0] angle0,
    input  logic [23:0] angle1,
    input  logic [23:0] angle2,
    input  logic [23:0] angle3,
`ifdef LIGHTHOUSE_EMITTER_OOTX_EN
    input  logic        ootx0_bit,
    input  logic        ootx1_bit,
    output logic        ootx_strobe,
`endif
    output logic        pin,
    output logic        frame_strobe,
    output logic [1:0]  frame_index,
    output logic        sweep_dropped
);

    // Sweep length is kept even and below the sensor's 15 us pulse limit.
    localparam int SWEEP_LIM  = SWEEP_MAX_US * CLOCKS_PER_MICROSECOND;
    localparam int SWEEP_HALF = ((SWEEP_LEN < SWEEP_LIM) ? SWEEP_LEN : SWEEP_LIM - 1) / 2;
    localparam int SWEEP_EFF  = 2 * SWEEP_HALF;
    localparam int EXT_W      = CNT_W + 2;
    localparam logic [CNT_W-1:0] LAST_T = CNT_W'(FRAME_CLOCKS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] angle_q, angle_d;
    logic             pin_q, pin_d;
    logic             strobe_q, strobe_d;
    logic             drop_q, drop_d;
    logic [1:0]       idx_q, idx_d;
    logic             data0_q, data0_d;
    logic             data1_q, data1_d;

    logic             motor, axis, skip1;
    logic             ootx0_in, ootx1_in;
    logic [CNT_W-1:0] len0, len1, start_angle;
    logic [1:0]       start_idx;
    logic             boundary, sweep_ok;
    logic [EXT_W-1:0] t_next, r_pos, sw_start, sw_end;

    assign motor = idx_q[1];
    assign axis  = ~idx_q[0];
    assign skip1 = ~motor;

`ifdef LIGHTHOUSE_EMITTER_OOTX_EN
    assign ootx0_in    = ootx0_bit;
    assign ootx1_in    = ootx1_bit;
    assign ootx_strobe = strobe_q;
`else
    assign ootx0_in = 1'b0;
    assign ootx1_in = 1'b0;
`endif

    lighthouse_sync_encode u_enc0 (
        .skip_i (motor),
        .data_i (data0_q),
        .axis_i (axis),
        .len_o  (len0)
    );

    lighthouse_sync_encode u_enc1 (
        .skip_i (skip1),
        .data_i (data1_q),
        .axis_i (axis),
        .len_o  (len1)
    );

    // Frame timeline boundaries, widened so angle + offsets cannot overflow.
    always_comb begin
        t_next   = EXT_W'(cnt_q) + EXT_W'(1);
        r_pos    = EXT_W'(SYNC_GAP) + EXT_W'(len1);
        sw_start = r_pos + EXT_W'(angle_q) - EXT_W'(SWEEP_HALF);
        sw_end   = r_pos + EXT_W'(angle_q) + EXT_W'(SWEEP_HALF);
        sweep_ok = (angle_q >= CNT_W'(SWEEP_EFF)) &&
                   (sw_end <= EXT_W'(FRAME_CLOCKS - 1));
    end

    // Pick the frame index and angle that a frame start would latch.
    always_comb begin
        boundary  = (state_q != ST_IDLE) && (cnt_q == LAST_T);
        start_idx = boundary ? idx_q + 2'd1 : idx_q;
        case (start_idx)
            2'd0:    start_angle = angle0;
            2'd1:    start_angle = angle1;
            2'd2:    start_angle = angle2;
            default: start_angle = angle3;
        endcase
    end

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        pin_d    = pin_q;
        strobe_d = 1'b0;
        drop_d   = 1'b0;
        idx_d    = idx_q;
        angle_d  = angle_q;
        data0_d  = data0_q;
        data1_d  = data1_q;

        if (state_q == ST_IDLE || boundary) begin
            idx_d = start_idx;
            cnt_d = '0;
            if (enable) begin
                state_d  = ST_SYNC0;
                pin_d    = 1'b0;
                strobe_d = 1'b1;
                angle_d  = start_angle;
                data0_d  = ootx0_in;
                data1_d  = ootx1_in;
            end else begin
                state_d = ST_IDLE;
                pin_d   = 1'b1;
            end
        end else begin
            case (state_q)
                ST_SYNC0: if (t_next == EXT_W'(len0)) begin
                    state_d = ST_GAP0;
                    pin_d   = 1'b1;
                end
                ST_GAP0: if (t_next == EXT_W'(SYNC_GAP)) begin
                    state_d = ST_SYNC1;
                    pin_d   = 1'b0;
                end
                ST_SYNC1: if (t_next == r_pos) begin
                    pin_d = 1'b1;
                    if (sweep_ok) begin
                        state_d = ST_WAIT_SWEEP;
                    end else begin
                        state_d = ST_TAIL;
                        drop_d  = 1'b1;
                    end
                end
                ST_WAIT_SWEEP: if (t_next == sw_start) begin
                    state_d = ST_SWEEP;
                    pin_d   = 1'b0;
                end
                ST_SWEEP: if (t_next == sw_end) begin
                    state_d = ST_TAIL;
                    pin_d   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State and output registers; reset aborts any frame with the pin high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pin_q    <= 1'b1;
            strobe_q <= 1'b0;
            drop_q   <= 1'b0;
            idx_q    <= 2'd0;
            angle_q  <= '0;
            data0_q  <= 1'b0;
            data1_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pin_q    <= pin_d;
            strobe_q <= strobe_d;
            drop_q   <= drop_d;
            idx_q    <= idx_d;
            angle_q  <= angle_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
        end
    end

    assign pin           = pin_q;
    assign frame_strobe  = strobe_q;
    assign frame_index   = idx_q;
    assign sweep_dropped = drop_q;

endmodule

// File: tb/tb_lighthouse_emitter.sv
// Self-checking bench for lighthouse_emitter with a shortened frame so that
// several whole frames fit in a short run. Expected pin waveforms come from
// the interval rules of the frame timeline.
module tb_lighthouse_emitter;

    localparam int CPU = 48;
    localparam int F   = 13500;
    localparam int GAP = 6700;
    localparam int SL  = 32;
    localparam int H   = SL / 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [23:0] ang [4];
    logic        pin;
    logic        frame_strobe;
    logic        sweep_dropped;
    logic [1:0]  frame_index;
`ifdef LIGHTHOUSE_EMITTER_OOTX_EN
    logic        ootx0;
    logic        ootx1;
    logic        ootx_strobe;
`endif

    int    errors = 0;
    int    checks = 0;
    int    plan_ang [8];
    bit    plan_d0  [8];
    bit    plan_d1  [8];
    int    tbl0 [4] = '{3584, 3072, 5632, 5120};
    int    tbl1 [4] = '{5632, 5120, 3584, 3072};
    int    falls[$];
    int    rises[$];
    int    drop_t;
    int    strobe_t;
    int    mis;
    string first_msg;

    always #5 clk = ~clk;

    lighthouse_emitter #(
        .CLOCKS_PER_MICROSECOND (CPU),
        .FRAME_CLOCKS           (F),
        .SYNC_GAP               (GAP),
        .SWEEP_LEN              (SL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .angle0        (ang[0]),
        .angle1        (ang[1]),
        .angle2        (ang[2]),
        .angle3        (ang[3]),
`ifdef LIGHTHOUSE_EMITTER_OOTX_EN
        .ootx0_bit     (ootx0),
        .ootx1_bit     (ootx1),
        .ootx_strobe   (ootx_strobe),
`endif
        .pin           (pin),
        .frame_strobe  (frame_strobe),
        .frame_index   (frame_index),
        .sweep_dropped (sweep_dropped)
    );

    // ---------------- reference model ----------------
    function automatic int sync_len(int skip, int data, int axis);
        return 3072 + axis * 512 + data * 1024 + skip * 2048;
    endfunction

    function automatic int len0_of(int k, bit d0);
        return sync_len((k >> 1) & 1, int'(d0), 1 - (k & 1));
    endfunction

    function automatic int r_of(int k, bit d1);
        return GAP + sync_len(1 - ((k >> 1) & 1), int'(d1), 1 - (k & 1));
    endfunction

    function automatic bit sweep_valid(int k, int a, bit d1);
        return (a >= SL) && (r_of(k, d1) + a + H <= F - 1);
    endfunction

    function automatic bit model_pin(int t, int k, int a, bit d0, bit d1);
        int  r;
        bit  low;
        r   = r_of(k, d1);
        low = (t < len0_of(k, d0)) || (t >= GAP && t < r) ||
              (sweep_valid(k, a, d1) && t >= r + a - H && t < r + a + H);
        return !low;
    endfunction

    task automatic make_plan();
        int k;
        int r;
        for (int f = 0; f < 8; f++) begin
            k = f % 4;
`ifdef LIGHTHOUSE_EMITTER_OOTX_EN
            plan_d0[f] = (f == 0) ? 1'b1 : 1'($urandom);
            plan_d1[f] = (f == 0) ? 1'b0 : 1'($urandom);
`else
            plan_d0[f] = 1'b0;
            plan_d1[f] = 1'b0;
`endif
            r = r_of(k, plan_d1[f]);
            if (f == 1)      plan_ang[f] = int'($urandom_range(SL - 1, 0));
            else if (f == 2) plan_ang[f] = F - r - H + int'($urandom_range(5000, 0));
            else             plan_ang[f] = int'($urandom_range(F - 1 - r - H, SL));
        end
    endtask

    // Runs ncyc cycles of frame f (index k) from t=0, comparing every cycle
    // against the model and recording pulse edges for the scenario checks.
    task automatic run_frame(input int f, input int k, input int ncyc,
                             input int en_off_at, input bit set_next);
        int    a;
        int    r;
        bit    d0;
        bit    d1;
        bit    ok;
        bit    exp_p;
        bit    exp_s;
        bit    exp_d;
        bit    prev;
        string m;
        a  = plan_ang[f];
        d0 = plan_d0[f];
        d1 = plan_d1[f];
        r  = r_of(k, d1);
        ok = sweep_valid(k, a, d1);
        falls.delete();
        rises.delete();
        drop_t    = -1;
        strobe_t  = -1;
        mis       = 0;
        first_msg = "";
        prev      = 1'b1;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            exp_p = model_pin(t, k, a, d0, d1);
            exp_s = (t == 0);
            exp_d = !ok && (t == r);
            m = "";
            if (pin !== exp_p)
                m = $sformatf("t=%0d pin got %b want %b", t, pin, exp_p);
            else if (frame_strobe !== exp_s)
                m = $sformatf("t=%0d frame_strobe got %b want %b", t, frame_strobe, exp_s);
            else if (sweep_dropped !== exp_d)
                m = $sformatf("t=%0d sweep_dropped got %b want %b", t, sweep_dropped, exp_d);
            else if (frame_index !== 2'(k))
                m = $sformatf("t=%0d frame_index got %0d want %0d", t, frame_index, k);
`ifdef LIGHTHOUSE_EMITTER_OOTX_EN
            else if (ootx_strobe !== exp_s)
                m = $sformatf("t=%0d ootx_strobe got %b want %b", t, ootx_strobe, exp_s);
`endif
            if (m != "") begin
                mis++;
                if (first_msg == "") first_msg = m;
            end
            if (pin === 1'b0 && prev) falls.push_back(t);
            if (pin === 1'b1 && !prev) rises.push_back(t);
            prev = (pin !== 1'b0);
            if (sweep_dropped === 1'b1 && drop_t < 0) drop_t = t;
            if (frame_strobe === 1'b1 && strobe_t < 0) strobe_t = t;
            if (t == 1000) begin
                for (int i = 0; i < 4; i++) ang[i] = 24'($urandom);
`ifdef LIGHTHOUSE_EMITTER_OOTX_EN
                ootx0 = 1'($urandom);
                ootx1 = 1'($urandom);
`endif
            end
            if (t == en_off_at) enable = 1'b0;
            if (set_next && t == ncyc - 1) begin
                ang[(k + 1) % 4] = 24'(plan_ang[f + 1]);
`ifdef LIGHTHOUSE_EMITTER_OOTX_EN
                ootx0 = plan_d0[f + 1];
                ootx1 = plan_d1[f + 1];
`endif
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int bad;
        reset  = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) ang[i] = '0;
`ifdef LIGHTHOUSE_EMITTER_OOTX_EN
        ootx0 = 1'b0;
        ootx1 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (pin !== 1'b1) begin errors++; $display("FAIL reset_pin: got %b want 1", pin); end
        checks++;
        if (frame_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", frame_strobe); end
        checks++;
        if (sweep_dropped !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", sweep_dropped); end
        checks++;
        if (frame_index !== 2'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", frame_index); end
`ifdef LIGHTHOUSE_EMITTER_OOTX_EN
        checks++;
        if (ootx_strobe !== 1'b0) begin errors++; $display("FAIL reset_ootx_strobe: got %b want 0", ootx_strobe); end
`endif
        reset = 1'b0;
        bad   = 0;
        repeat (20) begin
            @(negedge clk);
            if (frame_strobe !== 1'b0 || pin !== 1'b1 || frame_index !== 2'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL idle_hold: %0d bad cycles, want 0", bad); end
    endtask

    task automatic test_frame_timing();
        int a;
        int l0;
        int l1;
        int r;
        int ef [3];
        int er [3];
        int gf;
        int gr;
        a  = plan_ang[0];
        l0 = 3584 + 1024 * int'(plan_d0[0]);
        l1 = 5632 + 1024 * int'(plan_d1[0]);
        r  = GAP + l1;
        ef = '{0, GAP, r + a - H};
        er = '{l0, r, r + a + H};
        ang[0] = 24'(a);
`ifdef LIGHTHOUSE_EMITTER_OOTX_EN
        ootx0 = plan_d0[0];
        ootx1 = plan_d1[0];
`endif
        enable = 1'b1;
        run_frame(0, 0, F, -1, 1'b1);
        checks++;
        if (mis !== 0) begin errors++; $display("FAIL frame0_cycles: %0d bad cycles, first %s", mis, first_msg); end
        checks++;
        if (strobe_t !== 0) begin errors++; $display("FAIL frame0_strobe_t: got %0d want 0", strobe_t); end
        checks++;
        if (falls.size() !== 3) begin errors++; $display("FAIL frame0_pulses: got %0d want 3", falls.size()); end
        for (int i = 0; i < 3; i++) begin
            gf = (i < falls.size()) ? falls[i] : -1;
            gr = (i < rises.size()) ? rises[i] : -1;
            checks++;
            if (gf !== ef[i] || gr !== er[i]) begin
                errors++;
                $display("FAIL frame0_pulse%0d: got [%0d,%0d) want [%0d,%0d)", i, gf, gr, ef[i], er[i]);
            end
        end
        checks++;
        if (drop_t !== -1) begin errors++; $display("FAIL frame0_drop: got t=%0d want none", drop_t); end
    endtask

    task automatic test_four_frames();
        int e0;
        int e1;
        int g0;
        int g1;
        int edrop;
        int epulses;
        for (int f = 1; f < 4; f++) begin
            run_frame(f, f, F, (f == 3) ? F / 2 : -1, 1'b1);
            e0      = tbl0[f] + 1024 * int'(plan_d0[f]);
            e1      = tbl1[f] + 1024 * int'(plan_d1[f]);
            g0      = (falls.size() > 0 && rises.size() > 0 && falls[0] == 0) ? rises[0] : -1;
            g1      = (falls.size() > 1 && rises.size() > 1 && falls[1] == GAP) ? rises[1] - falls[1] : -1;
            edrop   = sweep_valid(f, plan_ang[f], plan_d1[f]) ? -1 : r_of(f, plan_d1[f]);
            epulses = (edrop < 0) ? 3 : 2;
            checks++;
            if (mis !== 0) begin errors++; $display("FAIL frame%0d_cycles: %0d bad cycles, first %s", f, mis, first_msg); end
            checks++;
            if (g0 !== e0) begin errors++; $display("FAIL frame%0d_sync0_len: got %0d want %0d", f, g0, e0); end
            checks++;
            if (g1 !== e1) begin errors++; $display("FAIL frame%0d_sync1_len: got %0d want %0d", f, g1, e1); end
            checks++;
            if (drop_t !== edrop) begin errors++; $display("FAIL frame%0d_drop_t: got %0d want %0d", f, drop_t, edrop); end
            checks++;
            if (falls.size() !== epulses) begin errors++; $display("FAIL frame%0d_pulses: got %0d want %0d", f, falls.size(), epulses); end
        end
    endtask

    task automatic test_enable_reenable();
        int bad;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (frame_strobe !== 1'b0 || pin !== 1'b1 || sweep_dropped !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL idle_after_disable: %0d bad cycles, want 0", bad); end
        checks++;
        if (frame_index !== 2'd0) begin errors++; $display("FAIL idle_index: got %0d want 0", frame_index); end
        enable = 1'b1;
        run_frame(4, 0, GAP + 101, -1, 1'b0);
        checks++;
        if (mis !== 0) begin errors++; $display("FAIL reenable_cycles: %0d bad cycles, first %s", mis, first_msg); end
        checks++;
        if (strobe_t !== 0) begin errors++; $display("FAIL reenable_strobe_t: got %0d want 0", strobe_t); end
    endtask

    task automatic test_reset_midframe();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (pin !== 1'b1) begin errors++; $display("FAIL midreset_pin: got %b want 1", pin); end
        checks++;
        if (frame_strobe !== 1'b0) begin errors++; $display("FAIL midreset_strobe: got %b want 0", frame_strobe); end
        checks++;
        if (frame_index !== 2'd0) begin errors++; $display("FAIL midreset_index: got %0d want 0", frame_index); end
        ang[0] = 24'(plan_ang[5]);
`ifdef LIGHTHOUSE_EMITTER_OOTX_EN
        ootx0 = plan_d0[5];
        ootx1 = plan_d1[5];
`endif
        reset = 1'b0;
        run_frame(5, 0, 300, -1, 1'b0);
        checks++;
        if (mis !== 0) begin errors++; $display("FAIL after_reset_cycles: %0d bad cycles, first %s", mis, first_msg); end
        checks++;
        if (strobe_t !== 0) begin errors++; $display("FAIL after_reset_strobe_t: got %0d want 0", strobe_t); end
    endtask

    initial begin
        make_plan();
        test_reset();
        test_frame_timing();
        test_four_frames();
        test_enable_reenable();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
